ifetch_queue: RTL and testbench

- Parametrised in-order fetch buffer between the PC/instruction-memory request channel and the ID stage.
- Allocates an entry when a fetch address is accepted, fills it when the in-order response returns, and presents the oldest filled entry to ID on a valid/ready handshake.
- On flush, it discards queued entries and silently drops responses still in flight for pre-flush requests.
- Drives request credit back-pressure to the PC stage.

---
 rtl/ifetch_queue.sv | 193 +++++++++++++++++++
 tb/tb_ifetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch buffer between the PC / instruction
// memory request channel and the ID stage.
//
// An entry is allocated when memory accepts a fetch address (req_fire), filled
// when the in-order response returns (resp_valid), and the oldest filled entry
// is offered to ID on out_valid/out_ready. A flush discards every entry and
// remembers how many pre-flush responses are still in flight so they can be
// dropped silently when they arrive.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   flush                  discard all entries and in-flight responses
//   fetch_allow            PC stage may issue a request this cycle
//   req_fire, req_pc       accepted fetch request and its PC
//   resp_valid, resp_data  in-order instruction response
//   out_valid, out_ready   head handshake towards ID
//   out_pc, out_inst       head entry contents
//   occupancy              allocated entries (filled plus unfilled)
//   discard_cnt            pre-flush responses still to be dropped
//   resp_orphan            sticky: a response arrived with nothing outstanding

// Invariant checker for the fetch queue bookkeeping.
module ifetch_queue_chk #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  input logic [CNT_W-1:0] count,
  input logic [CNT_W-1:0] pend,
  input logic [CNT_W-1:0] discard,
  input logic             out_valid,
  input logic             req_fire,
  input logic             fetch_allow
);
  logic [CNT_W:0] used_s;

  assign used_s = {1'b0, count} + {1'b0, discard};

  a_count_le_depth: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(DEPTH));
  a_pend_le_count: assert property (@(posedge clk) disable iff (reset)
    pend <= count);
  a_credit: assert property (@(posedge clk) disable iff (reset)
    used_s <= (CNT_W + 1)'(DEPTH));
  a_valid_nonempty: assert property (@(posedge clk) disable iff (reset)
    out_valid |-> (count != {CNT_W{1'b0}}));
  a_req_has_credit: assert property (@(posedge clk) disable iff (reset)
    req_fire |-> fetch_allow);
endmodule

module ifetch_queue #(
  parameter int  ADDR_W = 32,
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  output logic              fetch_allow,
  input  logic              req_fire,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  discard_cnt,
  output logic              resp_orphan
);
  localparam int SUM_W = CNT_W + 1;

  logic [PTR_W-1:0]  head_r, fill_r, tail_r;
  logic [CNT_W-1:0]  count_r, pend_r, discard_r;
  logic [DEPTH-1:0]  filled_r;
  logic              orphan_r;
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [DATA_W-1:0] inst_mem_r [DEPTH];

  logic              alloc_s, pop_s, fill_s, orphan_s, drop_s;
  logic [SUM_W-1:0]  credit_use_s, in_flight_s;
  logic [CNT_W-1:0]  flush_discard_s;
  logic              flush_orphan_s;

  // Handshake decode, response routing and flush discard arithmetic.
  always_comb begin
    alloc_s  = req_fire && !flush;
    pop_s    = filled_r[head_r] && out_ready && !flush;
    // Outstanding discards always take precedence over filling.
    drop_s   = resp_valid && !flush && (discard_r != {CNT_W{1'b0}});
    fill_s   = resp_valid && !flush && (discard_r == {CNT_W{1'b0}})
               && (pend_r != {CNT_W{1'b0}});
    orphan_s = resp_valid && !flush && (discard_r == {CNT_W{1'b0}})
               && (pend_r == {CNT_W{1'b0}});

    // Everything in flight at a flush: older discards, unfilled entries and a
    // same-cycle request. A same-cycle response retires one of them.
    in_flight_s = {1'b0, discard_r} + {1'b0, pend_r} + {{CNT_W{1'b0}}, req_fire};
    if (resp_valid && (in_flight_s != {SUM_W{1'b0}})) begin
      flush_discard_s = CNT_W'(in_flight_s - {{CNT_W{1'b0}}, 1'b1});
      flush_orphan_s  = 1'b0;
    end else begin
      flush_discard_s = CNT_W'(in_flight_s);
      flush_orphan_s  = resp_valid;
    end

    // Responses still owed for discarded requests hold their credit too.
    credit_use_s = {1'b0, count_r} + {1'b0, discard_r};
  end

  assign fetch_allow = credit_use_s < SUM_W'(DEPTH);
  assign out_valid   = filled_r[head_r];
  assign out_pc      = pc_mem_r[head_r];
  assign out_inst    = inst_mem_r[head_r];
  assign occupancy   = count_r;
  assign discard_cnt = discard_r;
  assign resp_orphan = orphan_r;

  // Pointer, counter, filled-bit and sticky-orphan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r    <= {PTR_W{1'b0}};
      fill_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      pend_r    <= {CNT_W{1'b0}};
      discard_r <= {CNT_W{1'b0}};
      filled_r  <= {DEPTH{1'b0}};
      orphan_r  <= 1'b0;
    end else if (flush) begin
      head_r    <= {PTR_W{1'b0}};
      fill_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      pend_r    <= {CNT_W{1'b0}};
      filled_r  <= {DEPTH{1'b0}};
      discard_r <= flush_discard_s;
      if (flush_orphan_s) begin
        orphan_r <= 1'b1;
      end
    end else begin
      // Allocate, fill and pop touch distinct slots whenever they coincide.
      if (alloc_s) begin
        filled_r[tail_r] <= 1'b0;
        tail_r           <= tail_r + PTR_W'(1'b1);
      end
      if (fill_s) begin
        filled_r[fill_r] <= 1'b1;
        fill_r           <= fill_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        filled_r[head_r] <= 1'b0;
        head_r           <= head_r + PTR_W'(1'b1);
      end
      count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
      pend_r  <= pend_r + CNT_W'(alloc_s) - CNT_W'(fill_s);
      if (drop_s) begin
        discard_r <= discard_r - CNT_W'(1'b1);
      end
      if (orphan_s) begin
        orphan_r <= 1'b1;
      end
    end
  end

  // Entry payload storage; contents are only meaningful behind a filled bit.
  always_ff @(posedge clk) begin
    if (alloc_s && !reset) begin
      pc_mem_r[tail_r] <= req_pc;
    end
    if (fill_s && !reset) begin
      inst_mem_r[fill_r] <= resp_data;
    end
  end

  ifetch_queue_chk #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .count      (count_r),
    .pend       (pend_r),
    .discard    (discard_r),
    .out_valid  (out_valid),
    .req_fire   (req_fire),
    .fetch_allow(fetch_allow)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue (DEPTH=8). A reference model keeps the
// allocated-but-unfilled PCs and the filled entries awaiting ID in queues;
// filled entries are popped and compared whenever ID accepts the head.
module tb_ifetch_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        fetch_allow;
  logic        req_fire;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  occupancy;
  logic [3:0]  discard_cnt;
  logic        resp_orphan;

  ifetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fetch_allow(fetch_allow),
    .req_fire   (req_fire),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .occupancy  (occupancy),
    .discard_cnt(discard_cnt),
    .resp_orphan(resp_orphan)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] alloc_q[$];
  ent_t        exp_q[$];
  int          m_disc   = 0;
  bit          m_orphan = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, advance the model, step past the edge.
  task automatic tick();
    ent_t e;
    int   occ;
    int   inflight;
    #4;
    occ = alloc_q.size() + exp_q.size();
    if (chk_en) begin
      check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check_eq("occupancy", 64'(occupancy), 64'(occ));
      check_eq("discard_cnt", 64'(discard_cnt), 64'(m_disc));
      check_eq("fetch_allow", 64'(fetch_allow), 64'((occ + m_disc) < 8));
      check_eq("resp_orphan", 64'(resp_orphan), 64'(m_orphan));
    end
    if (reset) begin
      alloc_q.delete();
      exp_q.delete();
      m_disc   = 0;
      m_orphan = 1'b0;
    end else if (flush) begin
      inflight = m_disc + alloc_q.size() + (req_fire ? 1 : 0);
      if (resp_valid) begin
        if (inflight > 0) inflight--;
        else m_orphan = 1'b1;
      end
      m_disc = inflight;
      alloc_q.delete();
      exp_q.delete();
    end else begin
      if (out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_pc", 64'(out_pc), 64'(e.pc));
        check_eq("out_inst", 64'(out_inst), 64'(e.inst));
      end
      if (resp_valid) begin
        if (m_disc > 0) m_disc--;
        else if (alloc_q.size() != 0) exp_q.push_back({alloc_q.pop_front(), resp_data});
        else m_orphan = 1'b1;
      end
      if (req_fire) alloc_q.push_back(req_pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rf, input logic [31:0] pc, input logic rv,
                       input logic [31:0] d, input logic rdy, input logic fl);
    req_fire   = rf;
    req_pc     = pc;
    resp_valid = rv;
    resp_data  = d;
    out_ready  = rdy;
    flush      = fl;
    tick();
  endtask

  // Hard stop should the run ever stall.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int owed;
    int resp_idx;
    bit rf;
    bit rv;

    reset = 1'b1; flush = 1'b0; req_fire = 1'b0; req_pc = 32'h0;
    resp_valid = 1'b0; resp_data = 32'h0; out_ready = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_fetch_allow", 64'(fetch_allow), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);

    // Stream: responses two cycles after each request, ID always ready.
    drive(1'b1, 32'h100, 1'b0, 32'h0,  1'b1, 1'b0);
    drive(1'b1, 32'h104, 1'b0, 32'h0,  1'b1, 1'b0);
    drive(1'b1, 32'h108, 1'b1, 32'hA0, 1'b1, 1'b0);
    check_eq("stream_first_valid", 64'(out_valid), 64'd1);
    check_eq("stream_first_pc", 64'(out_pc), 64'h100);
    drive(1'b0, 32'h0,   1'b1, 32'hA1, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'hA2, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0);
    check_eq("stream_drained", 64'(occupancy), 64'd0);

    // Back-pressure: fill all eight entries while ID stalls.
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 32'h1000 + 32'(4 * i), (i >= 2), 32'hC0 + 32'(i - 2), 1'b0, 1'b0);
    end
    check_eq("full_occupancy", 64'(occupancy), 64'd8);
    check_eq("full_fetch_allow", 64'(fetch_allow), 64'd0);

    // Drain and keep fetching up to 20 requests so the pointers wrap twice.
    issued = 8; owed = 0; resp_idx = 8;
    for (int c = 0; c < 200; c++) begin
      if (issued == 20 && owed == 0 && occupancy == 4'd0) break;
      rf = (issued < 20) && fetch_allow;
      rv = (owed > 0);
      drive(rf, 32'h1000 + 32'(4 * issued), rv, 32'hC0 + 32'(resp_idx), 1'b1, 1'b0);
      if (rf) begin issued++; owed++; end
      if (rv) begin owed--; resp_idx++; end
    end
    check_eq("wrap_requests", 64'(issued), 64'd20);
    check_eq("wrap_drained", 64'(occupancy), 64'd0);

    // Flush with three allocated, one filled, nothing else that cycle.
    drive(1'b1, 32'h300, 1'b0, 32'h0,  1'b0, 1'b0);
    drive(1'b1, 32'h304, 1'b0, 32'h0,  1'b0, 1'b0);
    drive(1'b1, 32'h308, 1'b0, 32'h0,  1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'hD0, 1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1);
    check_eq("flush_occupancy", 64'(occupancy), 64'd0);
    check_eq("flush_discard", 64'(discard_cnt), 64'd2);
    check_eq("flush_fetch_allow", 64'(fetch_allow), 64'd1);
    drive(1'b0, 32'h0,   1'b1, 32'hD1, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'hD2, 1'b1, 1'b0);
    check_eq("flush_dropped_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h200, 1'b0, 32'h0,  1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'hB0, 1'b1, 1'b0);
    check_eq("post_flush_pc", 64'(out_pc), 64'h200);
    check_eq("post_flush_inst", 64'(out_inst), 64'hB0);
    drive(1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0);

    // Flush colliding with a request and a response, head filled and ID ready.
    drive(1'b1, 32'h400, 1'b0, 32'h0,  1'b0, 1'b0);
    drive(1'b1, 32'h404, 1'b0, 32'h0,  1'b0, 1'b0);
    drive(1'b1, 32'h408, 1'b0, 32'h0,  1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'hE0, 1'b0, 1'b0);
    drive(1'b1, 32'h40C, 1'b1, 32'hE1, 1'b1, 1'b1);
    check_eq("coll_discard", 64'(discard_cnt), 64'd2);
    check_eq("coll_orphan", 64'(resp_orphan), 64'd0);
    check_eq("coll_occupancy", 64'(occupancy), 64'd0);
    drive(1'b0, 32'h0,   1'b1, 32'hE2, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'hE3, 1'b1, 1'b0);
    check_eq("coll_discard_done", 64'(discard_cnt), 64'd0);

    // Orphan response with nothing outstanding; the flag must stick.
    drive(1'b0, 32'h0,   1'b1, 32'hDEAD, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b0);
    drive(1'b1, 32'h700, 1'b0, 32'h0,    1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'h70,   1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b0);
    check_eq("orphan_sticky", 64'(resp_orphan), 64'd1);
    check_eq("orphan_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-operation: five allocated, two discards pending.
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h510 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0);
    end
    check_eq("pre_rst_occupancy", 64'(occupancy), 64'd5);
    check_eq("pre_rst_discard", 64'(discard_cnt), 64'd2);
    reset = 1'b1;
    drive(1'b1, 32'h600, 1'b1, 32'h66, 1'b1, 1'b0);
    reset = 1'b0;
    check_eq("rst_mid_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_mid_discard", 64'(discard_cnt), 64'd0);
    check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_fetch_allow", 64'(fetch_allow), 64'd1);
    check_eq("rst_mid_orphan", 64'(resp_orphan), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
